// File: rtl/trap_ctrl.sv
// Trap controller: prioritises interrupts/exceptions, stalls until drain, then commits the trap and redirects to mtvec.
// Optional macro TRAP_CTRL_IRQ_SYNC_EN adds a 2-flop synchroniser on i_irq.
module trap_ctrl #(
    parameter int XLEN           = 32,
    parameter int NUM_IRQ        = 3,
    parameter int IRQ_CAUSE_BASE = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [XLEN-1:0]    i_inst,
    input  logic [XLEN-1:0]    i_ls_addr,
    input  logic [15:0]        i_exc,
    input  logic               i_mret,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_mie_global,
    input  logic [NUM_IRQ-1:0] i_mie,
    input  logic [XLEN-1:0]    i_mtvec,
    input  logic [XLEN-1:0]    i_mepc,
    input  logic               i_flush_ack,
    output logic               o_kill,
    output logic               o_stall,
    output logic               o_trap_take,
    output logic               o_mret_take,
    output logic               o_is_irq,
    output logic [4:0]         o_cause,
    output logic [XLEN-1:0]    o_epc,
    output logic [XLEN-1:0]    o_tval,
    output logic               o_redirect,
    output logic [XLEN-1:0]    o_redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_COMMIT} state_t;

    state_t            r_state;
    logic              r_stall;
    logic              r_trap_take;
    logic              r_redirect;
    logic              r_is_irq;
    logic [4:0]        r_cause;
    logic [XLEN-1:0]   r_epc;
    logic [XLEN-1:0]   r_tval;
    logic [XLEN-1:0]   r_redirect_pc;

    logic [NUM_IRQ-1:0] w_irq_src;
    logic [NUM_IRQ-1:0] w_irq_pend;
    logic               w_irq_any;
    logic [4:0]         w_irq_idx;
    logic               w_exc_any;
    logic [4:0]         w_exc_cause;
    logic [XLEN-1:0]    w_exc_tval;
    logic               w_eval;
    logic               w_trap;
    logic               w_mret;
    logic [4:0]         w_cause;
    logic [XLEN-1:0]    w_tval;
    logic [XLEN-1:0]    w_base;
    logic [XLEN-1:0]    w_target;
    logic               w_unused_exc;

`ifdef TRAP_CTRL_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_irq_meta;
    logic [NUM_IRQ-1:0] r_irq_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_meta <= '0;
            r_irq_sync <= '0;
        end else begin
            r_irq_meta <= i_irq;
            r_irq_sync <= r_irq_meta;
        end
    end
    assign w_irq_src = r_irq_sync;
`else
    assign w_irq_src = i_irq;
`endif

    assign w_irq_pend   = w_irq_src & i_mie & {NUM_IRQ{i_mie_global}};
    assign w_irq_any    = |w_irq_pend;
    assign w_unused_exc = ^{i_exc[15:12], i_exc[10:8]};

    // Scan downwards so the lowest pending line wins.
    always_comb begin
        w_irq_idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (w_irq_pend[k]) w_irq_idx = 5'(k);
        end
    end

    always_comb begin
        w_exc_any   = 1'b1;
        w_exc_cause = 5'd0;
        w_exc_tval  = '0;
        if (i_exc[1])       begin w_exc_cause = 5'd1;  w_exc_tval = i_pc;      end
        else if (i_exc[2])  begin w_exc_cause = 5'd2;  w_exc_tval = i_inst;    end
        else if (i_exc[0])  begin w_exc_cause = 5'd0;  w_exc_tval = i_pc;      end
        else if (i_exc[11]) begin w_exc_cause = 5'd11;                         end
        else if (i_exc[3])  begin w_exc_cause = 5'd3;                          end
        else if (i_exc[5])  begin w_exc_cause = 5'd5;  w_exc_tval = i_ls_addr; end
        else if (i_exc[7])  begin w_exc_cause = 5'd7;  w_exc_tval = i_ls_addr; end
        else if (i_exc[4])  begin w_exc_cause = 5'd4;  w_exc_tval = i_ls_addr; end
        else if (i_exc[6])  begin w_exc_cause = 5'd6;  w_exc_tval = i_ls_addr; end
        else                      w_exc_any   = 1'b0;
    end

    assign w_eval   = i_rst_n && (r_state == S_IDLE) && i_valid;
    assign w_trap   = w_eval && (w_irq_any || w_exc_any);
    assign w_mret   = w_eval && i_mret && !w_irq_any && !w_exc_any;
    assign w_cause  = w_irq_any ? 5'(IRQ_CAUSE_BASE) + w_irq_idx : w_exc_cause;
    assign w_tval   = w_irq_any ? '0 : w_exc_tval;
    assign w_base   = {i_mtvec[XLEN-1:2], 2'b00};
    assign w_target = (w_irq_any && i_mtvec[1:0] == 2'b01) ? w_base + (XLEN'(w_cause) << 2) : w_base;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_stall       <= 1'b0;
            r_trap_take   <= 1'b0;
            r_redirect    <= 1'b0;
            r_is_irq      <= 1'b0;
            r_cause       <= '0;
            r_epc         <= '0;
            r_tval        <= '0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trap) begin
                        r_state       <= S_HOLD;
                        r_stall       <= 1'b1;
                        r_is_irq      <= w_irq_any;
                        r_cause       <= w_cause;
                        r_epc         <= i_pc;
                        r_tval        <= w_tval;
                        r_redirect_pc <= w_target;
                    end
                end
                S_HOLD: begin
                    if (i_flush_ack) begin
                        r_state     <= S_COMMIT;
                        r_trap_take <= 1'b1;
                        r_redirect  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_stall     <= 1'b0;
                    r_trap_take <= 1'b0;
                    r_redirect  <= 1'b0;
                end
            endcase
        end
    end

    assign o_kill        = w_trap;
    assign o_stall       = r_stall;
    assign o_trap_take   = r_trap_take;
    assign o_mret_take   = w_mret;
    assign o_is_irq      = r_is_irq;
    assign o_cause       = r_cause;
    assign o_epc         = r_epc;
    assign o_tval        = r_tval;
    assign o_redirect    = r_redirect | w_mret;
    assign o_redirect_pc = w_mret ? i_mepc : (r_redirect ? r_redirect_pc : '0);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios followed by randomized transactions against a priority-table model.
module tb_trap_ctrl;

    localparam int XLEN = 32;
    localparam int NIRQ = 3;
`ifdef TRAP_CTRL_IRQ_SYNC_EN
    localparam int IRQ_LAT = 2;
`else
    localparam int IRQ_LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid;
    logic [31:0]     pc, inst, ls_addr, mtvec, mepc;
    logic [15:0]     exc;
    logic            mret, mieg, flush_ack;
    logic [NIRQ-1:0] irq, mie;
    logic            kill, stall, trap_take, mret_take, is_irq, redirect;
    logic [4:0]      cause;
    logic [31:0]     epc, tval, redirect_pc;

    int checks = 0;
    int failures = 0;

    // Model outputs
    logic        m_trap, m_irq, m_mret;
    logic [4:0]  m_cause;
    logic [31:0] m_tval, m_rpc;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NIRQ), .IRQ_CAUSE_BASE(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pc(pc), .i_inst(inst),
        .i_ls_addr(ls_addr), .i_exc(exc), .i_mret(mret), .i_irq(irq),
        .i_mie_global(mieg), .i_mie(mie), .i_mtvec(mtvec), .i_mepc(mepc),
        .i_flush_ack(flush_ack), .o_kill(kill), .o_stall(stall),
        .o_trap_take(trap_take), .o_mret_take(mret_take), .o_is_irq(is_irq),
        .o_cause(cause), .o_epc(epc), .o_tval(tval), .o_redirect(redirect),
        .o_redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the priority table; interrupts before exceptions before mret.
    task automatic model();
        int order [9] = '{1, 2, 0, 11, 3, 5, 7, 4, 6};
        logic [NIRQ-1:0] pend;
        logic [31:0] base;
        pend    = mieg ? (irq & mie) : '0;
        m_trap  = 1'b0;
        m_irq   = 1'b0;
        m_cause = 5'd0;
        m_tval  = 32'd0;
        for (int k = NIRQ - 1; k >= 0; k--)
            if (pend[k]) begin m_trap = 1'b1; m_irq = 1'b1; m_cause = 5'(16 + k); end
        if (!m_irq)
            for (int j = 8; j >= 0; j--)
                if (exc[order[j]]) begin m_trap = 1'b1; m_cause = 5'(order[j]); end
        if (m_trap && !m_irq) begin
            if (m_cause <= 1)                      m_tval = pc;
            else if (m_cause == 2)                 m_tval = inst;
            else if (m_cause >= 4 && m_cause <= 7) m_tval = ls_addr;
        end
        m_mret = !m_trap && mret;
        base   = mtvec & 32'hFFFF_FFFC;
        m_rpc  = (m_irq && mtvec[1:0] == 2'b01) ? base + 32'(m_cause) * 4 : base;
    endtask

    // Entered just after the decision-cycle inputs are driven; d = cycles with flush_ack low in HOLD.
    task automatic do_trap(input int d, input logic [31:0] exp_epc);
        model();
        chk("kill", 32'(kill), 32'(1));
        step();
        for (int c = 0; c < d; c++) begin
            #1;
            chk("hold_stall", 32'(stall), 32'(1));
            chk("hold_take", 32'(trap_take), 32'(0));
            chk("hold_kill", 32'(kill), 32'(0));
            step();
        end
        flush_ack = 1'b1;
        #1;
        chk("ack_stall", 32'(stall), 32'(1));
        chk("ack_mret", 32'(mret_take), 32'(0));
        step();
        flush_ack = 1'b0;
        valid     = 1'b0;
        #1;
        chk("commit_take", 32'(trap_take), 32'(1));
        chk("commit_redir", 32'(redirect), 32'(1));
        chk("commit_stall", 32'(stall), 32'(1));
        chk("commit_irq", 32'(is_irq), 32'(m_irq));
        chk("commit_cause", 32'(cause), 32'(m_cause));
        chk("commit_epc", epc, exp_epc);
        chk("commit_tval", tval, m_tval);
        chk("commit_rpc", redirect_pc, m_rpc);
        $display("trap cause=%0d irq=%0d epc=%08h tval=%08h rpc=%08h ack_delay=%0d",
                 m_cause, m_irq, exp_epc, m_tval, m_rpc, d);
        step();
        chk("post_take", 32'(trap_take), 32'(0));
        chk("post_stall", 32'(stall), 32'(0));
        chk("post_cause_held", 32'(cause), 32'(m_cause));
    endtask

    task automatic idle_inputs();
        valid = 0; pc = 0; inst = 0; ls_addr = 0; exc = 0; mret = 0;
        irq = 0; mie = 0; mieg = 0; mtvec = 0; mepc = 0; flush_ack = 0;
    endtask

    initial begin
        logic [31:0] r;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_cause", 32'(cause), 32'(0));
        chk("rst_rpc", redirect_pc, 32'(0));
        rst_n = 1'b1;
        step();

        // Reset while in HOLD drops the pending trap.
        valid = 1; pc = 32'h100; inst = 32'hFFFF_FFFF; exc = 16'h0004;
        #1;
        chk("rh_kill", 32'(kill), 32'(1));
        step();
        chk("rh_stall", 32'(stall), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rh_r_stall", 32'(stall), 32'(0));
        chk("rh_r_kill", 32'(kill), 32'(0));
        chk("rh_r_cause", 32'(cause), 32'(0));
        chk("rh_r_epc", epc, 32'(0));
        chk("rh_r_tval", tval, 32'(0));
        chk("rh_r_redir", 32'(redirect), 32'(0));
        valid = 0; exc = 0; flush_ack = 1;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rh_no_take", 32'(trap_take), 32'(0));
            chk("rh_no_stall", 32'(stall), 32'(0));
        end
        flush_ack = 0;

        // Illegal instruction, drain acknowledged on the third HOLD cycle.
        valid = 1; pc = 32'h100; inst = 32'hFFFF_FFFF; exc = 16'h0004; mtvec = 32'h8000_0000;
        #1;
        do_trap(2, 32'h100);

        // Load access fault beats load misaligned.
        valid = 1; pc = 32'h300; ls_addr = 32'h1003; exc = 16'h0030;
        #1;
        do_trap(0, 32'h300);
        chk("ld_cause", 32'(cause), 32'd5);

        // Vectored interrupt beats ecall.
        irq = 3'b010; mie = 3'b111; mieg = 1; mtvec = 32'h8000_0001;
        repeat (IRQ_LAT) step();
        valid = 1; pc = 32'h400; exc = 16'h0800;
        #1;
        do_trap(1, 32'h400);
        chk("vec_rpc_const", epc, 32'h400);

        // Global MIE gating.
        idle_inputs();
        irq = 3'b001; mie = 3'b111; mieg = 0; mtvec = 32'h8000_0001;
        repeat (IRQ_LAT) step();
        valid = 1; pc = 32'h500;
        #1;
        chk("gate_kill", 32'(kill), 32'(0));
        step();
        chk("gate_stall", 32'(stall), 32'(0));
        mieg = 1;
        #1;
        do_trap(0, 32'h500);

        // mret alone, then mret with illegal instruction.
        idle_inputs();
        step();
        valid = 1; mret = 1; mepc = 32'h200;
        #1;
        chk("mret_take", 32'(mret_take), 32'(1));
        chk("mret_redir", 32'(redirect), 32'(1));
        chk("mret_rpc", redirect_pc, 32'h200);
        chk("mret_stall", 32'(stall), 32'(0));
        chk("mret_kill", 32'(kill), 32'(0));
        step();
        chk("mret_idle", 32'(stall), 32'(0));
        pc = 32'h600; inst = 32'h3020_0073; exc = 16'h0004;
        #1;
        chk("mret_exc_take", 32'(mret_take), 32'(0));
        do_trap(0, 32'h600);
        idle_inputs();

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            idle_inputs();
            irq  = NIRQ'($urandom);
            mie  = NIRQ'($urandom);
            mieg = 1'($urandom_range(0, 1));
            r    = $urandom;
            mtvec = r;
            r = $urandom_range(0, 3);
            if (r >= 1) exc[$urandom_range(0, 15)] = 1'b1;
            if (r >= 2) exc[$urandom_range(0, 15)] = 1'b1;
            mret = 1'($urandom_range(0, 1));
            for (int c = 0; c < IRQ_LAT; c++) begin
                step();
                chk("rnd_idle_kill", 32'(kill), 32'(0));
            end
            valid = 1; pc = $urandom; inst = $urandom; ls_addr = $urandom; mepc = $urandom;
            #1;
            model();
            if (m_trap) begin
                do_trap($urandom_range(0, 3), pc);
            end else begin
                chk("rnd_kill", 32'(kill), 32'(0));
                chk("rnd_mret", 32'(mret_take), 32'(m_mret));
                chk("rnd_redir", 32'(redirect), 32'(m_mret));
                if (m_mret) chk("rnd_mret_rpc", redirect_pc, mepc);
                $display("no-trap mret=%0d mepc=%08h", m_mret, mepc);
                step();
                chk("rnd_nostall", 32'(stall), 32'(0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequential successor to the combinational trap dispatcher.
- Prioritises synchronous exceptions and a parametrised set of interrupt lines, and latches the winning trap with its cause, tval and epc.
- Stalls the pipeline until drain is acknowledged, then issues a one-cycle trap-commit pulse to the CSR file and a PC redirect to mtvec (direct or vectored).
- Also handles mret redirects. Sits between the execute/memory stages and the machine CSR block.

Parameters:
- XLEN, 32, datapath and CSR width (MXLEN = XLEN).
- NUM_IRQ, 3, number of interrupt lines, 1..16.
- IRQ_CAUSE_BASE, 16, cause code of i_irq[0]; line k has cause IRQ_CAUSE_BASE+k. IRQ_CAUSE_BASE+NUM_IRQ must be <= 32.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  instruction in commit slot is valid
- i_pc  in  XLEN  PC of commit-slot instruction
- i_inst  in  XLEN  instruction word
- i_ls_addr  in  XLEN  load/store effective address
- i_exc  in  16  exception flags indexed by standard cause code (0..15)
- i_mret  in  1  commit-slot instruction is mret
- i_irq  in  NUM_IRQ  level interrupt requests
- i_mie_global  in  1  mstatus.MIE
- i_mie  in  NUM_IRQ  per-line enable
- i_mtvec  in  XLEN  mtvec; bits[1:0] are mode: 0 direct, 1 vectored
- i_mepc  in  XLEN  current mepc, used for mret
- i_flush_ack  in  1  pipeline drained
- o_kill  out  1  combinational; suppress commit of current instruction
- o_stall  out  1  hold fetch/commit
- o_trap_take  out  1  one-cycle pulse; CSR file writes mcause/mepc/mtval and clears MIE
- o_mret_take  out  1  one-cycle pulse; CSR file restores MIE
- o_is_irq  out  1  mcause interrupt bit
- o_cause  out  5  mcause code
- o_epc  out  XLEN  value for mepc
- o_tval  out  XLEN  value for mtval
- o_redirect  out  1  one-cycle PC redirect strobe
- o_redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: every output is 0; state is IDLE; latched cause/epc/tval are 0. Assertion of i_rst_n at any state forces this immediately, and any pending trap is dropped.
- States:
  - IDLE: evaluate requests.
  - HOLD: trap latched; o_stall=1; wait for i_flush_ack.
  - COMMIT: o_stall=1, o_trap_take=1, o_redirect=1 for exactly one cycle, then return to IDLE.
- Evaluation happens only in IDLE with i_valid=1.
- Interrupt pending vector = i_irq & i_mie, gated by i_mie_global.
- Priority, highest first:
  - any pending interrupt (lowest index wins);
  - exceptions in this order: inst access fault (1), illegal inst (2), inst misaligned (0), ecall-M (11), breakpoint (3), load access fault (5), store access fault (7), load misaligned (4), store misaligned (6);
  - mret.
- Any other i_exc bit is ignored.
- tval per cause:
  - causes 1 and 0: i_pc
  - cause 2: i_inst
  - causes 4–7: i_ls_addr
  - ecall, breakpoint, interrupts: 0
- epc = i_pc for all traps. An interrupted instruction is killed and re-executes after mret.
- On a trap decision in cycle N:
  - o_kill=1 in cycle N;
  - cause/tval/epc/is_irq are latched;
  - state is HOLD from N+1.
- Latched values drive o_cause/o_tval/o_epc/o_is_irq and stay stable through HOLD and COMMIT. They are held after COMMIT until the next trap.
- HOLD ignores new exceptions, interrupts and mret. i_flush_ack in cycle M moves to COMMIT in M+1. i_flush_ack already high on the first HOLD cycle is accepted, giving minimum trap latency of 2 cycles to o_trap_take.
- Redirect target:
  - direct mode, or any exception: {i_mtvec[XLEN-1:2],2'b00}
  - vectored mode with an interrupt: base + 4*cause, modulo 2^XLEN
  - mtvec mode values 2 and 3 are treated as direct.
- mret with no exception/interrupt in IDLE:
  - o_mret_take=1, o_redirect=1, o_redirect_pc=i_mepc, all combinationally in the same cycle;
  - no stall, state stays IDLE.
- An exception on the mret instruction beats the mret: the exception is taken and no o_mret_take is issued.
- i_valid=0 in IDLE: no action. Interrupts are deferred until a valid instruction is at commit.

Optional Feature:
- Macro TRAP_CTRL_IRQ_SYNC_EN.
- When defined: i_irq passes through a 2-flop synchroniser (reset 0) before gating, adding 2 cycles of interrupt latency.
- When undefined: i_irq is used directly; it must already be synchronous to i_clk.

Test Plan:
- Reset mid-HOLD: illegal inst (i_exc[2]=1, i_inst=32'hFFFF_FFFF) at pc 32'h100, drop i_rst_n during HOLD -> all outputs 0 and IDLE at once; release reset -> no trap_take.
- Illegal inst with flush_ack delayed 3 cycles: illegal inst at pc 32'h100, mtvec=32'h8000_0000 -> o_kill in cycle N; o_stall N+1..N+4; o_trap_take and o_redirect at N+4 with cause=2, tval=32'hFFFF_FFFF, epc=32'h100, redirect_pc=32'h8000_0000.
- Simultaneous load misaligned (4) and load access fault (5), ls_addr=32'h1003, flush_ack=1 -> COMMIT at N+2 with cause=5, tval=32'h1003.
- Vectored interrupt with exception pending: i_irq[1]=1, mie=3'b111, MIE=1, mtvec=32'h8000_0001, ecall also set -> is_irq=1, cause=17, tval=0, redirect_pc=32'h8000_0044.
- Interrupt gating: i_irq[0]=1 with MIE=0 -> no kill, no trap. Raise MIE -> trap on next i_valid cycle (plus 2 cycles when TRAP_CTRL_IRQ_SYNC_EN is defined).
- mret: i_mret=1, i_mepc=32'h200 -> same-cycle o_mret_take, o_redirect_pc=32'h200, o_stall=0. mret with i_exc[2]=1 -> trap with cause 2, no o_mret_take.
